// File: rtl/dinorun_pkg.sv
// Shared types and constants for the dino-run game.
// Used by the game controller and by the sprite, score and obstacle blocks.
//   state_t        - top-level game state, encoded as it appears on state_o
//   frame_cnt_t    - width of the per-state frame counter
//   ctrl_out_t     - bundle of the per-state control outputs
//   decode_outputs - maps (state, blink phase) to the control outputs
package dinorun_pkg;

  typedef enum logic [1:0] {
    StTitle    = 2'd0,
    StReady    = 2'd1,
    StPlay     = 2'd2,
    StGameOver = 2'd3
  } state_t;

  // Default frame budgets, at 60 frames per second.
  localparam int unsigned DefBlinkFrames = 30;
  localparam int unsigned DefReadyFrames = 60;
  localparam int unsigned DefHoldFrames  = 90;

  localparam int unsigned FrameCntW = 8;
  typedef logic [FrameCntW-1:0] frame_cnt_t;

  typedef struct packed {
    logic title_en;
    logic run;
    logic game_rst;
  } ctrl_out_t;

  // Control outputs that belong to a given state. The blink phase only matters in the title
  // screen; game over shows the title sprite steadily.
  function automatic ctrl_out_t decode_outputs(input state_t state, input logic phase);
    ctrl_out_t outs;
    outs = '{title_en: 1'b0, run: 1'b0, game_rst: 1'b0};
    case (state)
      StTitle:    outs.title_en = phase;
      StReady:    outs.game_rst = 1'b1;
      StPlay:     outs.run      = 1'b1;
      StGameOver: outs.title_en = 1'b1;
      default:    outs = '{title_en: 1'b0, run: 1'b0, game_rst: 1'b0};
    endcase
    return outs;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for the debounced start/jump button.
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   btn_i  - debounced button level
//   edge_o - high for the cycle in which btn_i is 1 and its registered previous value is 0
// The previous-value register resets to 1, so a button held through reset release does not
// count as a press.
module edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic edge_o
);

  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= btn_i;
    end
  end

  assign edge_o = btn_i & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Top-level game state machine for the dino-run game.
//   clk_i         - clock
//   rst_i         - asynchronous active-high reset
//   frame_pulse_i - one-cycle pulse per VGA frame
//   start_btn_i   - debounced start/jump button level
//   collision_i   - dino/obstacle overlap flag
//   state_o       - current state (TITLE, READY, PLAY, GAME_OVER)
//   title_en_o    - gate for the title sprite pixel (blinks in TITLE, steady in GAME_OVER)
//   run_o         - world scroll/score enable (PLAY only)
//   game_rst_o    - clears score, obstacles and dino position (READY only)
// Every output comes straight from a flop, so the pixel path sees no decode glitches.
module game_ctrl
  import dinorun_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = DefBlinkFrames,  // frames per title blink phase
  parameter int unsigned READY_FRAMES = DefReadyFrames,  // frames in READY before PLAY
  parameter int unsigned HOLD_FRAMES  = DefHoldFrames    // frames in GAME_OVER before restart
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   frame_pulse_i,
  input  logic   start_btn_i,
  input  logic   collision_i,
  output state_t state_o,
  output logic   title_en_o,
  output logic   run_o,
  output logic   game_rst_o
);

  localparam frame_cnt_t BlinkLast = frame_cnt_t'(BLINK_FRAMES - 1);
  localparam frame_cnt_t ReadyLast = frame_cnt_t'(READY_FRAMES - 1);
  localparam frame_cnt_t HoldCount = frame_cnt_t'(HOLD_FRAMES);
  localparam frame_cnt_t CntOne    = frame_cnt_t'(1);

  localparam ctrl_out_t ResetOuts = '{title_en: 1'b1, run: 1'b0, game_rst: 1'b0};

  logic       start_edge;

  state_t     state_q, state_d;
  frame_cnt_t cnt_q, cnt_d;
  logic       phase_q, phase_d;
  ctrl_out_t  outs_q;

  edge_detect u_edge_detect (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (start_btn_i),
    .edge_o (start_edge)
  );

  // Next-state logic. Every transition clears the frame counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;

    unique case (state_q)
      StTitle: begin
        // A start press wins over a frame pulse landing in the same cycle.
        if (start_edge) begin
          state_d = StReady;
          cnt_d   = '0;
        end else if (frame_pulse_i) begin
          if (cnt_q == BlinkLast) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

      StReady: begin
        // Button and collision are deliberately ignored while the world is being reset.
        if (frame_pulse_i) begin
          if (cnt_q == ReadyLast) begin
            state_d = StPlay;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

      StPlay: begin
        // The counter is idle here; only a collision ends the run.
        if (collision_i) begin
          state_d = StGameOver;
          cnt_d   = '0;
        end
      end

      StGameOver: begin
        // Restart presses are only honoured once the hold time has fully elapsed; the counter
        // saturates so a long idle period cannot wrap it back below the threshold.
        if (start_edge && (cnt_q == HoldCount)) begin
          state_d = StReady;
          cnt_d   = '0;
        end else if (frame_pulse_i && (cnt_q != HoldCount)) begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        state_d = StTitle;
        cnt_d   = '0;
        phase_d = 1'b1;
      end
    endcase
  end

  // State, counter, blink phase and the registered outputs. Outputs are decoded from the
  // next state so they line up with state_q in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StTitle;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      outs_q  <= ResetOuts;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      outs_q  <= decode_outputs(state_d, phase_d);
    end
  end

  assign state_o    = state_q;
  assign title_en_o = outs_q.title_en;
  assign run_o      = outs_q.run;
  assign game_rst_o = outs_q.game_rst;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter BLINK_FRAMES, default 30: frames per title blink phase, 1..255.
REQ-002 SHALL have parameter READY_FRAMES, default 60: frames spent in READY before PLAY, 1..255.
REQ-003 SHALL have parameter HOLD_FRAMES, default 90: frames in GAME_OVER before a restart is accepted, 1..255.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port frame_pulse_i, input, 1 bit: one-cycle pulse per VGA frame.
REQ-007 SHALL have port start_btn_i, input, 1 bit: debounced start/jump button level.
REQ-008 SHALL have port collision_i, input, 1 bit: dino/obstacle overlap flag.
REQ-009 SHALL have port state_o, output, state_t (2 bits): current state.
REQ-010 SHALL have port title_en_o, output, 1 bit: gate for the title sprite pixel.
REQ-011 SHALL have port run_o, output, 1 bit: world scroll/score enable.
REQ-012 SHALL have port game_rst_o, output, 1 bit: clears score, obstacles and dino position.

Function
REQ-013 SHALL have states TITLE=0, READY=1, PLAY=2, GAME_OVER=3; state_o SHALL be the state register, with no added latency.
REQ-014 SHALL detect a start edge when start_btn_i=1 this cycle and the registered previous value=0.
REQ-015 SHALL, in TITLE, count frame pulses 0..BLINK_FRAMES-1 and toggle the blink phase on the pulse that wraps the count.
REQ-016 SHALL, in TITLE, drive title_en_o = blink phase, run_o=0 and game_rst_o=0.
REQ-017 SHALL, in TITLE, move to READY on a start edge and clear the frame counter; if a frame pulse occurs in the same cycle, the transition takes priority.
REQ-018 SHALL, in READY, drive title_en_o=0, run_o=0 and game_rst_o=1.
REQ-019 SHALL, in READY, count frame pulses and move to PLAY on the pulse that brings the count to READY_FRAMES; start edges and collision SHALL be ignored.
REQ-020 SHALL, in PLAY, drive title_en_o=0, run_o=1 and game_rst_o=0.
REQ-021 SHALL, in PLAY, move to GAME_OVER in the cycle after collision_i=1 is sampled, regardless of a frame pulse in the same cycle; start edges SHALL be ignored.
REQ-022 SHALL, in GAME_OVER, drive title_en_o=1 (steady), run_o=0 and game_rst_o=0.
REQ-023 SHALL, in GAME_OVER, count frame pulses saturating at HOLD_FRAMES, and ignore start edges until the count equals HOLD_FRAMES.
REQ-024 SHALL, in GAME_OVER, move to READY on a start edge once the count equals HOLD_FRAMES, clearing the counter.
REQ-025 SHALL clear the frame counter on every state transition.
REQ-026 SHALL use an 8-bit frame counter that never wraps outside TITLE.
REQ-027 SHALL make all outputs pure functions of registered state and phase, so they are glitch-free for the pixel path.

Reset
REQ-028 SHALL asynchronously set, while rst_i=1: state=TITLE, frame counter=0, blink phase=1, previous-button register=1.
REQ-029 SHALL therefore, during and after reset, output state_o=TITLE, title_en_o=1, run_o=0 and game_rst_o=0.
REQ-030 SHALL NOT produce a start edge from a button held through reset deassertion.
REQ-031 SHALL return to TITLE with the reset values when reset is asserted mid-READY or mid-PLAY, regardless of counter value.

Structure
REQ-032 SHALL define state_t (2-bit enum) and default frame constants in dinorun_pkg, shared with the sprite, score and obstacle blocks.
REQ-033 SHALL instantiate one sub-module, edge_detect, which registers the button and outputs the start-edge pulse, with its own reset value of 1.
REQ-034 SHALL keep the FSM and counter in game_ctrl, with no other sub-modules.

Verification (BLINK_FRAMES=4, READY_FRAMES=3, HOLD_FRAMES=5)
REQ-035 SHALL check: reset, then 8 frame pulses with no button -> title_en_o sequence per frame 1,1,1,1,0,0,0,0; 9th pulse period -> 1; state stays TITLE.
REQ-036 SHALL check: button held through reset release -> no transition; release then press -> READY next cycle, game_rst_o=1; 3 frame pulses -> PLAY, run_o=1, game_rst_o=0.
REQ-037 SHALL check: in PLAY, collision_i=1 coincident with frame_pulse_i -> GAME_OVER next cycle, run_o=0, title_en_o=1.
REQ-038 SHALL check: in GAME_OVER, start edges after 2 and 4 pulses -> ignored; start edge after 5th pulse -> READY with counter 0.
REQ-039 SHALL check: start edge and frame pulse in the same TITLE cycle -> READY, counter 0; collision during READY -> ignored, PLAY reached after 3 pulses.
REQ-040 SHALL check: rst_i asserted mid-PLAY asynchronously (between clock edges) -> state_o=TITLE, title_en_o=1 before the next clock edge.
